hilo_mdu: RTL
=============

Name: hilo_mdu

Overview:
- Iterative multiply/divide unit that owns the HI/LO register pair for the EX stage.
- Runs alongside the combinational ALU and takes the same two operands (rs value, rt value).
- Produces a 64-bit product or a quotient/remainder pair over multiple cycles.
- Exposes busy/done so the pipeline controller can stall dependent MFHI/MFLO.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  operation request; sampled only in IDLE
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved
- a  in  WIDTH  rs operand (multiplicand / dividend / MTHI-MTLO source)
- b  in  WIDTH  rt operand (multiplier / divisor)
- busy  out  1  high while an iterative op is in flight
- done  out  1  one-cycle pulse when HI/LO are updated by MULT*/DIV*
- div0  out  1  one-cycle pulse, coincident with done, when a DIV/DIVU had b==0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

Behaviour:
- Reset: state=IDLE; hi=0, lo=0, busy=0, done=0, div0=0; internal accumulators cleared.
- Reset mid-operation aborts the operation; HI/LO still go to 0.
- States: IDLE, CALC, FIX.
- IDLE, start=1, op=MTHI: hi<=a at that edge. No busy, no done. Stay in IDLE.
- IDLE, start=1, op=MTLO: lo<=a at that edge. No busy, no done. Stay in IDLE.
- IDLE, start=1, op=MULT*/DIV*, edge E0:
  - Latch operand magnitudes. Signed ops take the absolute value; -2^31 maps to unsigned 2^31.
  - Latch result sign flags.
  - Clear the iteration counter.
  - busy<=1; go to CALC.
- CALC: exactly WIDTH cycles (edges E1..E32), one bit per cycle.
  - Multiply: shift-add on the 2*WIDTH accumulator.
  - Divide: restoring division with a WIDTH+1-bit partial remainder, one quotient bit per cycle.
  - After the WIDTH-th iteration, go to FIX.
- FIX (edge E33):
  - Apply sign correction.
  - Multiply: {hi,lo} <= 64-bit product.
  - Divide: lo<=quotient, hi<=remainder.
  - done<=1 and busy<=0 for the cycle after E33; return to IDLE.
- Latency: results are visible on hi/lo exactly 33 cycles after the start edge.
- Signed multiply: product is negated iff exactly one operand is negative.
- Signed divide:
  - Quotient truncates toward zero and is negated iff the operand signs differ.
  - Remainder takes the sign of the dividend.
- DIV -2^31 / -1: lo=0x80000000 (wraps), hi=0. No flag.
- Divide by zero (b==0, DIV or DIVU):
  - Still takes the full 33 cycles.
  - hi/lo are left unchanged.
  - done=1 and div0=1 pulse together.
- start while busy is ignored; the operation in flight is unaffected.
- Operand inputs a/b may change freely after E0.
- Reserved op codes with start=1 in IDLE: no effect, no busy.
- A start in the same cycle done is high is accepted (the unit is in IDLE), so back-to-back ops are spaced by 34 edges.
- hi/lo are never modified while busy=1, except by reset.

Test Plan:
- Reset, then MTHI a=0x12345678 and MTLO a=0x9ABCDEF0 -> next cycle hi=0x12345678, lo=0x9ABCDEF0, busy never high, done never pulses.
- MULT a=-3 (0xFFFFFFFD), b=7 -> busy for 33 cycles; done pulse; hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7, b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- DIVU a=7, b=0 with hi/lo preloaded to 0x11/0x22 -> done and div0 pulse together after 33 cycles; hi=0x11, lo=0x22 unchanged.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Sequence check 1: start MULT, pulse start with DIV at cycle 10 -> ignored, MULT result only.
- Sequence check 2: assert rst at cycle 20 of a DIV -> next cycle hi=lo=0, busy=0, no done.

Source files
------------

// File: rtl/hilo_mdu_if.sv
// Operation request and HI/LO result bundle between the EX stage and the
// iterative multiply/divide unit.
interface hilo_mdu_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic             div0;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    // Pipeline side: issues requests, observes status and HI/LO.
    modport master (
        output start, op, a, b,
        input  busy, done, div0, hi, lo
    );

    // Unit side: accepts requests, owns HI/LO.
    modport slave (
        input  start, op, a, b,
        output busy, done, div0, hi, lo
    );
endinterface

// File: rtl/hilo_mdu.sv
// Iterative multiply/divide unit owning HI/LO. One bit per cycle for WIDTH
// cycles, then one cycle of sign fix-up before HI/LO are written.
module hilo_mdu #(
    parameter int WIDTH = 32
) (
    input logic         clk,
    input logic         rst,
    hilo_mdu_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    // Multiply: {partial product, multiplier}. Divide: low half holds the
    // dividend being shifted out while quotient bits shift in.
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;     // divide partial remainder
    logic [WIDTH-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
    logic               is_div_q, is_div_d;
    logic               zero_q, zero_d;   // divide by zero seen at start
    logic               neg_q, neg_d;     // negate product / quotient
    logic               rneg_q, rneg_d;   // negate remainder
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;
    logic               div0_q, div0_d;

    logic               sgn;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     shifted;
    logic               qbit;

    // Next-state, datapath step and HI/LO update.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        rneg_d   = rneg_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        div0_d   = 1'b0;
        sgn      = ~bus.op[0];
        mag_a    = (sgn && bus.a[WIDTH-1]) ? -bus.a : bus.a;
        mag_b    = (sgn && bus.b[WIDTH-1]) ? -bus.b : bus.b;
        sum      = '0;
        shifted  = '0;
        qbit     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MTHI: hi_d = bus.a;
                        OP_MTLO: lo_d = bus.a;
                        OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                            is_div_d = bus.op[1];
                            zero_d   = bus.op[1] && (bus.b == '0);
                            neg_d    = sgn && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                            rneg_d   = sgn && bus.a[WIDTH-1];
                            acc_d    = {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
                            opb_d    = bus.op[1] ? mag_b : mag_a;
                            rem_d    = '0;
                            cnt_d    = '0;
                            state_d  = CALC;
                        end
                        default: ;
                    endcase
                end
            end
            CALC: begin
                if (is_div_q) begin
                    // Restoring step: shift next dividend bit in, subtract if it fits.
                    shifted = {rem_q, acc_q[WIDTH-1]};
                    if (shifted >= {1'b0, opb_q}) begin
                        qbit  = 1'b1;
                        rem_d = WIDTH'(shifted - {1'b0, opb_q});
                    end else begin
                        rem_d = shifted[WIDTH-1:0];
                    end
                    acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], qbit};
                end else begin
                    // Shift-add step on the low multiplier bit.
                    sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                          + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
                    acc_d = {sum, acc_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (is_div_q) begin
                    if (zero_q) begin
                        div0_d = 1'b1;
                    end else begin
                        lo_d = neg_q  ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                        hi_d = rneg_q ? -rem_q : rem_q;
                    end
                end else begin
                    {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            div0_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            rneg_q   <= rneg_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
            div0_q   <= div0_d;
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.div0 = div0_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
